pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, number of pipeline stages; legal range 2..8; stage 0 is fetch, stage NSTAGE-1 is writeback.
REQ-002 SHALL have parameter BUS_W, default 64, width of every inter-stage bus register.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port s_over, input, NSTAGE, per-stage "work done" flag from the stage logic.
REQ-006 SHALL have port s_bus_in, input, (NSTAGE-1)*BUS_W, segment i (bits i*BUS_W +: BUS_W) is data from stage i to stage i+1.
REQ-007 SHALL have port flush, input, 1, pipeline kill request.
REQ-008 SHALL have port flush_src, input, 3, index of the stage raising flush.
REQ-009 SHALL have port s_valid, output, NSTAGE, per-stage valid.
REQ-010 SHALL have port s_allow_in, output, NSTAGE, per-stage ready-to-accept.
REQ-011 SHALL have port next_fetch, output, 1, advance-PC strobe to fetch.
REQ-012 SHALL have port s_bus_r, output, (NSTAGE-1)*BUS_W, registered buses; segment i feeds stage i+1.
REQ-013 SHALL have port valid_disp, output, 32, display word.
REQ-014 SHALL have port retire_cnt, output, 32, retired-instruction count.
REQ-015 SHALL have port stall_cnt, output, 32, fetch-stall cycle count.

Function
REQ-016 SHALL clamp flush_src: value 0 treated as 1, values >= NSTAGE treated as NSTAGE-1; k denotes the clamped value.
REQ-017 SHALL compute eff_over[i] = s_over[i] & s_valid[i] & ~(flush & i < k); the source stage k itself is never masked.
REQ-018 SHALL compute s_allow_in[NSTAGE-1] = ~s_valid[NSTAGE-1] | eff_over[NSTAGE-1].
REQ-019 SHALL compute s_allow_in[i] = ~s_valid[i] | (eff_over[i] & s_allow_in[i+1]) for 1 <= i <= NSTAGE-2, combinationally.
REQ-020 SHALL compute s_allow_in[0] = (eff_over[0] & s_allow_in[1]) | flush; next_fetch = s_allow_in[0].
REQ-021 SHALL set s_valid[0] to 0 in reset and to 1 on every cycle after reset deasserts.
REQ-022 SHALL, for i >= 1, clear s_valid[i] when flush and i <= k; else load eff_over[i-1] when s_allow_in[i]; else hold.
REQ-023 SHALL load bus segment i with s_bus_in segment i when eff_over[i] & s_allow_in[i+1]; else hold; flush does not block loads.
REQ-024 SHALL leave stages above k untouched during flush; stage k's own result propagates to stage k+1 if accepted.
REQ-025 SHALL increment retire_cnt by 1 in each cycle eff_over[NSTAGE-1] = 1, including the cycle a flush is raised by stage NSTAGE-1.
REQ-026 SHALL increment stall_cnt by 1 in each cycle s_valid[0] & ~s_allow_in[0].
REQ-027 SHALL wrap both counters modulo 2^32 (0xFFFFFFFF + 1 -> 0).
REQ-028 SHALL drive valid_disp = zero-extended concatenation {4{s_valid[0]}, ..., {4{s_valid[NSTAGE-1]}}}, stage 0 most significant.
REQ-029 SHALL have zero latency from a stage's eff_over to its allow_in and one-cycle latency from acceptance to the next stage's valid.

Reset
REQ-030 SHALL, while resetn = 0 at a clock edge, set s_valid, s_bus_r, retire_cnt and stall_cnt to 0, overriding flush and all loads.
REQ-031 SHALL produce s_allow_in[i] = 1 for i >= 1 during reset; s_allow_in[0] = flush during reset.
REQ-032 SHALL recover from reset asserted mid-operation with no stale valid or bus state on the first post-reset cycle.

Verification
REQ-033 SHALL cover: NSTAGE=5, all s_over=1, no flush, 20 cycles after reset -> valid_disp=0x000FFFFF from cycle 5, retire_cnt=16 after cycle 20.
REQ-034 SHALL cover: s_over[2]=0 for 3 cycles with full pipe -> s_allow_in[0..2]=0, stall_cnt +3, s_bus_r segments 0,1 held, stage 3 drains.
REQ-035 SHALL cover: flush=1, flush_src=4 (NSTAGE=5) for one cycle -> next cycle s_valid=5'b00001 (stage 0 only), retire_cnt +1 for stage 4.
REQ-036 SHALL cover: flush=1, flush_src=2 with full pipe -> stages 1,2 cleared, stage 3 valid (from stage 2), stage 4 retires normally.
REQ-037 SHALL cover: retire_cnt preloaded near wrap by 0xFFFFFFFF retires in simulation (or forced) -> next retire gives 0.
REQ-038 SHALL cover: resetn=0 for one cycle mid-stream with flush=1 -> all valid 0, counters 0, s_bus_r 0; s_valid[0]=1 one cycle later.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Valid/allow-in handshake controller for an NSTAGE in-order pipeline with flush and stats counters.
// Latency: allow_in is combinational from eff_over; acceptance reaches the next stage valid after 1 cycle.
// Backpressure: a stalled stage holds its valid and bus; the stall ripples back to fetch in the same cycle.
module pipeline_ctrl #(
    parameter int NSTAGE = 5,
    parameter int BUS_W  = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NSTAGE-1:0]             s_over,
    input  logic [(NSTAGE-1)*BUS_W-1:0]   s_bus_in,
    input  logic                          flush,
    input  logic [2:0]                    flush_src,
    output logic [NSTAGE-1:0]             s_valid,
    output logic [NSTAGE-1:0]             s_allow_in,
    output logic                          next_fetch,
    output logic [(NSTAGE-1)*BUS_W-1:0]   s_bus_r,
    output logic [31:0]                   valid_disp,
    output logic [31:0]                   retire_cnt,
    output logic [31:0]                   stall_cnt
);

    localparam logic [3:0] NS4  = 4'(NSTAGE);
    localparam logic [2:0] KMAX = 3'(NSTAGE - 1);

    logic [2:0]        k;
    logic [NSTAGE-1:0] mask;
    logic [NSTAGE-1:0] clr;
    logic [NSTAGE-1:0] eff_over;

    // Fetch can never be the flush source, and out-of-range sources collapse onto writeback.
    always_comb begin
        k = flush_src;
        if (flush_src == 3'd0)
            k = 3'd1;
        else if ({1'b0, flush_src} >= NS4)
            k = KMAX;
    end

    always_comb begin
        mask     = '0;
        clr      = '0;
        eff_over = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            mask[i]     = flush && (3'(i) < k);
            clr[i]      = flush && (3'(i) <= k);
            eff_over[i] = s_over[i] & s_valid[i] & ~mask[i];
        end
    end

    always_comb begin : allow_chain
        logic [NSTAGE-1:0] a;
        a = '0;
        a[NSTAGE-1] = ~s_valid[NSTAGE-1] | eff_over[NSTAGE-1];
        for (int i = NSTAGE - 2; i >= 1; i--)
            a[i] = ~s_valid[i] | (eff_over[i] & a[i+1]);
        a[0] = (eff_over[0] & a[1]) | flush;
        // Stale valid bits may still be visible before the first reset edge.
        if (!resetn) begin
            a    = '1;
            a[0] = flush;
        end
        s_allow_in = a;
    end

    assign next_fetch = s_allow_in[0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_valid    <= '0;
            s_bus_r    <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            s_valid[0] <= 1'b1;
            for (int i = 1; i < NSTAGE; i++) begin
                if (clr[i])
                    s_valid[i] <= 1'b0;
                else if (s_allow_in[i])
                    s_valid[i] <= eff_over[i-1];
            end
            for (int i = 0; i < NSTAGE - 1; i++) begin
                if (eff_over[i] & s_allow_in[i+1])
                    s_bus_r[i*BUS_W +: BUS_W] <= s_bus_in[i*BUS_W +: BUS_W];
            end
            if (eff_over[NSTAGE-1])
                retire_cnt <= retire_cnt + 32'd1;
            if (s_valid[0] & ~s_allow_in[0])
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        valid_disp = '0;
        for (int i = 0; i < NSTAGE; i++)
            valid_disp[4*(NSTAGE-1-i) +: 4] = {4{s_valid[i]}};
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (NSTAGE=5, BUS_W=16): fill, stall, flushes, counter wrap, mid-stream reset.
module tb_pipeline_ctrl;

    localparam int NSTAGE = 5;
    localparam int BUS_W  = 16;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic [NSTAGE-1:0]           s_over;
    logic [(NSTAGE-1)*BUS_W-1:0] s_bus_in;
    logic                        flush;
    logic [2:0]                  flush_src;
    logic [NSTAGE-1:0]           s_valid;
    logic [NSTAGE-1:0]           s_allow_in;
    logic                        next_fetch;
    logic [(NSTAGE-1)*BUS_W-1:0] s_bus_r;
    logic [31:0]                 valid_disp;
    logic [31:0]                 retire_cnt;
    logic [31:0]                 stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [63:0] P1 = 64'hA3A3_A2A2_A1A1_A0A0;
    localparam logic [63:0] P2 = 64'hB3B3_B2B2_B1B1_B0B0;
    localparam logic [63:0] P3 = 64'hC3C3_C2C2_C1C1_C0C0;
    localparam logic [63:0] P4 = 64'hD3D3_D2D2_D1D1_D0D0;

    pipeline_ctrl #(.NSTAGE(NSTAGE), .BUS_W(BUS_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_over     (s_over),
        .s_bus_in   (s_bus_in),
        .flush      (flush),
        .flush_src  (flush_src),
        .s_valid    (s_valid),
        .s_allow_in (s_allow_in),
        .next_fetch (next_fetch),
        .s_bus_r    (s_bus_r),
        .valid_disp (valid_disp),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        s_over    = '0;
        s_bus_in  = P1;
        flush     = 1'b0;
        flush_src = 3'd0;
        tick(2);
        check("rst_valid",  64'(s_valid),    64'h0);
        check("rst_disp",   64'(valid_disp), 64'h0);
        check("rst_retire", 64'(retire_cnt), 64'h0);
        check("rst_stall",  64'(stall_cnt),  64'h0);
        check("rst_bus",    s_bus_r,         64'h0);
        check("rst_allow",  64'(s_allow_in), 64'h1E);
        flush = 1'b1;
        #1;
        check("rst_allow_flush", 64'(s_allow_in), 64'h1F);
        check("rst_next_fetch",  64'(next_fetch), 64'h1);
        flush = 1'b0;

        // Fill: stage i becomes valid at edge i+1 after release; writeback retires from edge 6 on.
        resetn = 1'b1;
        s_over = '1;
        tick(1);
        check("fill_e1_valid", 64'(s_valid), 64'h01);
        check("fill_e1_disp",  64'(valid_disp), 64'hF0000);
        tick(3);
        check("fill_e4_disp",  64'(valid_disp), 64'hFFFF0);
        tick(1);
        check("fill_e5_disp",  64'(valid_disp), 64'hFFFFF);
        check("fill_e5_retire", 64'(retire_cnt), 64'h0);
        tick(16);
        check("fill_e21_retire", 64'(retire_cnt), 64'd16);
        check("fill_e21_stall",  64'(stall_cnt),  64'h0);
        check("fill_e21_bus",    s_bus_r,         P1);

        // Stage 2 stalls for three edges while stage 3 drains.
        s_bus_in = P2;
        s_over   = 5'b11011;
        #1;
        check("stall_allow", 64'(s_allow_in), 64'h18);
        check("stall_nf",    64'(next_fetch), 64'h0);
        tick(1);
        check("stall_e1_valid", 64'(s_valid), 64'h17);
        tick(2);
        check("stall_valid",  64'(s_valid),    64'h07);
        check("stall_cnt3",   64'(stall_cnt),  64'd3);
        check("stall_retire", 64'(retire_cnt), 64'd18);
        check("stall_bus",    s_bus_r,         64'hB3B3_A2A2_A1A1_A0A0);
        s_over = '1;
        tick(2);
        check("refill_disp",   64'(valid_disp), 64'hFFFFF);
        check("refill_retire", 64'(retire_cnt), 64'd18);
        check("refill_bus",    s_bus_r,         P2);

        // Flush raised by writeback: everything behind fetch dies, writeback still retires.
        flush     = 1'b1;
        flush_src = 3'd4;
        s_bus_in  = P3;
        #1;
        check("fl4_allow", 64'(s_allow_in), 64'h11);
        check("fl4_nf",    64'(next_fetch), 64'h1);
        tick(1);
        flush = 1'b0;
        check("fl4_valid",  64'(s_valid),    64'h01);
        check("fl4_retire", 64'(retire_cnt), 64'd19);
        check("fl4_stall",  64'(stall_cnt),  64'd3);
        check("fl4_bus",    s_bus_r,         P2);

        // Refill, then flush from stage 2: stages 1,2 cleared, stage 2 result moves on.
        tick(4);
        check("fl2_pre_disp", 64'(valid_disp), 64'hFFFFF);
        flush     = 1'b1;
        flush_src = 3'd2;
        s_bus_in  = P4;
        #1;
        check("fl2_allow", 64'(s_allow_in), 64'h1D);
        tick(1);
        check("fl2_valid",  64'(s_valid),    64'h19);
        check("fl2_retire", 64'(retire_cnt), 64'd20);
        check("fl2_bus",    s_bus_r,         64'hD3D3_D2D2_C1C1_C0C0);

        // flush_src 0 acts as 1: only stage 1 cleared.
        flush_src = 3'd0;
        tick(1);
        check("fl0_valid",  64'(s_valid),    64'h11);
        check("fl0_retire", 64'(retire_cnt), 64'd21);
        // flush_src 7 acts as 4: writeback unmasked and retires.
        flush_src = 3'd7;
        tick(1);
        flush = 1'b0;
        check("fl7_valid",  64'(s_valid),    64'h01);
        check("fl7_retire", 64'(retire_cnt), 64'd22);

        // Counter wrap.
        tick(4);
        check("wrap_pre_disp", 64'(valid_disp), 64'hFFFFF);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        check("wrap_preload", 64'(retire_cnt), 64'hFFFF_FFFF);
        tick(1);
        check("wrap_zero", 64'(retire_cnt), 64'h0);

        // One-cycle reset mid-stream with flush pending.
        resetn    = 1'b0;
        flush     = 1'b1;
        flush_src = 3'd3;
        #1;
        check("mrst_allow", 64'(s_allow_in), 64'h1F);
        tick(1);
        check("mrst_valid",  64'(s_valid),    64'h0);
        check("mrst_disp",   64'(valid_disp), 64'h0);
        check("mrst_retire", 64'(retire_cnt), 64'h0);
        check("mrst_stall",  64'(stall_cnt),  64'h0);
        check("mrst_bus",    s_bus_r,         64'h0);
        resetn = 1'b1;
        flush  = 1'b0;
        #1;
        check("mrst_rel_allow", 64'(s_allow_in), 64'h1E);
        tick(1);
        check("mrst_e1_valid", 64'(s_valid),   64'h01);
        check("mrst_e1_stall", 64'(stall_cnt), 64'h0);
        check("mrst_e1_bus",   s_bus_r,        64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
